// File: rtl/task_8_deserializer.sv
// Serial byte stream to N_BYTES frame deserializer with a one-frame ready/valid output buffer.
// Frame assembly and the output buffer run independently, so a back-to-back stream never stalls.
module task_8_deserializer #(
  parameter int N_BYTES     = 16,
  parameter int GAP_TIMEOUT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_ready,
  output logic [7:0]  o_data [N_BYTES],
  output logic        o_valid,
  output logic        o_overflow,
  output logic        o_trunc,
  output logic [15:0] o_frame_cnt
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_TIMEOUT);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       asm_q [N_BYTES];

  logic byte_wr, frame_done, gap_inc, gap_expire, buf_free;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_valid && !frame_done) state_nxt = S_COLLECT;
      S_COLLECT: if (frame_done || gap_expire) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Control outputs; the index is held at 0 in IDLE, so one compare covers both states
  always_comb begin
    byte_wr    = i_valid;
    frame_done = i_valid && (idx == LAST_IDX);
    gap_inc    = (state == S_COLLECT) && !i_valid;
    gap_expire = gap_inc && (gap_cnt == GAP_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx     <= '0;
      gap_cnt <= '0;
      o_trunc <= 1'b0;
    end else begin
      o_trunc <= gap_expire;
      if (byte_wr) begin
        idx     <= frame_done ? '0 : idx + 1'b1;
        gap_cnt <= '0;
      end else if (gap_expire) begin
        idx     <= '0;
        gap_cnt <= '0;
      end else if (gap_inc && gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // NOTE: the assembly array has no reset; every byte is written before it is copied out.
  always_ff @(posedge i_clk) begin
    if (byte_wr) asm_q[idx] <= i_data;
  end

  assign buf_free = !o_valid || i_ready;

  // Output buffer: the final byte comes straight from i_data so the frame loads on its own edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_BYTES; i++) o_data[i] <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_frame_cnt <= '0;
    end else if (frame_done && buf_free) begin
      for (int i = 0; i < N_BYTES; i++)
        o_data[i] <= (i == N_BYTES - 1) ? i_data : asm_q[i];
      o_valid     <= 1'b1;
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end else begin
      if (frame_done)          o_overflow <= 1'b1;
      if (o_valid && i_ready)  o_valid    <= 1'b0;
    end
  end

endmodule
